pixel_stream_source: RTL and testbench
======================================

PIXEL_STREAM_SOURCE -- requirements
Module: pixel_stream_source

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter IMG_WIDTH, default 224, pixels per row.
REQ-003 Parameter IMG_HEIGHT, default 224, rows per frame.
REQ-004 Parameter ADDR_WIDTH, default 16, memory address width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 start  in  1  one-cycle frame request.
REQ-009 base_addr  in  ADDR_WIDTH  frame start address, sampled on accepted start.
REQ-010 busy  out  1  high while a frame is in progress.
REQ-011 done  out  1  one-cycle pulse at frame completion.
REQ-012 mem_rd_en  out  1  memory read strobe.
REQ-013 mem_addr  out  ADDR_WIDTH  read address, valid with mem_rd_en.
REQ-014 mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-015 m_valid  out  1  output pixel valid.
REQ-016 m_ready  in  1  downstream accept; line-buffer ce = m_valid && m_ready.
REQ-017 m_data  out  DATA_WIDTH  output pixel.
REQ-018 m_sol / m_eol  out  1 each  first / last pixel of a row, qualified by m_valid.
REQ-019 m_sof / m_eof  out  1 each  first / last pixel of the frame, qualified by m_valid.

Function
REQ-020 States SHALL be IDLE, STREAM, DONE; IDLE->STREAM on start; STREAM->DONE on the handshake of the eof pixel; DONE->IDLE after exactly one cycle.
REQ-021 start SHALL be ignored outside IDLE; busy SHALL be high in STREAM and DONE.
REQ-022 Pixels SHALL be fetched in raster order; pixel k (0..IMG_WIDTH*IMG_HEIGHT-1) reads address base_addr + k, modulo 2^ADDR_WIDTH.
REQ-023 Read data SHALL be captured into a 2-entry output FIFO one cycle after its mem_rd_en.
REQ-024 mem_rd_en SHALL assert in STREAM only while reads remain and (FIFO count + reads in flight − pop this cycle) < 2; the FIFO SHALL never overflow.
REQ-025 With m_ready held high, the block SHALL sustain one pixel per cycle after the first pixel, with no bubbles across row boundaries.
REQ-026 First m_valid SHALL assert 2 cycles after the cycle start is accepted.
REQ-027 While m_valid && !m_ready, m_data and all flags SHALL hold stable; m_valid SHALL not deassert until the handshake.
REQ-028 Flags SHALL derive from output-side x/y counters advanced on handshake: sol at x=0, eol at x=IMG_WIDTH-1, sof at x=0,y=0, eof at x=IMG_WIDTH-1,y=IMG_HEIGHT-1.
REQ-029 IMG_WIDTH=1 SHALL assert sol and eol together; a single-pixel frame SHALL assert all four flags together.
REQ-030 done SHALL pulse in the DONE cycle, one cycle after the eof handshake; a start in that same cycle SHALL be ignored.
REQ-031 Exactly IMG_WIDTH*IMG_HEIGHT reads and handshakes SHALL occur per frame.

Reset
REQ-032 On rst_n=0 at a clock edge: state IDLE, FIFO empty, counters zero, busy/done/mem_rd_en/m_valid/flags 0, mem_addr 0, m_data 0.
REQ-033 Reset mid-frame SHALL abandon the frame; read data returning the cycle after reset SHALL be discarded; no done pulse.

Verification
REQ-034 IMG_WIDTH=4, IMG_HEIGHT=3, base_addr=0x0100, m_ready=1, memory returns addr[7:0] -> 12 pixels 0x00..0x0B on consecutive cycles, sol at 0,4,8, eol at 3,7,11, sof at 0, eof at 11, done one cycle later.
REQ-035 Same frame, m_ready toggling 1,0,0,1 repeating -> identical data/flag sequence, stable outputs during stalls, never more than 2 reads outstanding-plus-buffered.
REQ-036 base_addr=0xFFFE, 4x3 frame -> addresses 0xFFFE, 0xFFFF, 0x0000 ... 0x0009.
REQ-037 start asserted in STREAM and in DONE cycle -> ignored; single frame, one done pulse.
REQ-038 rst_n low after 5 handshakes, then new start -> outputs cleared, new frame begins at pixel 0 with sof, no stale data emitted.
REQ-039 IMG_WIDTH=1, IMG_HEIGHT=1 -> one pixel with sol, eol, sof, eof all high, done next cycle.

Source files
------------

// File: rtl/pixel_stream_source.sv
// Raster-order pixel source: reads a frame from memory and streams it out through
// a 2-entry output FIFO with row/frame framing flags and valid/ready handshaking.
module pixel_stream_source #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_sol_o,
  output logic                  m_eol_o,
  output logic                  m_sof_o,
  output logic                  m_eof_o
);

  localparam int NumPixels = IMG_WIDTH * IMG_HEIGHT;
  localparam int CntW      = $clog2(NumPixels + 1);
  localparam int XW        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CntW-1:0] TotalReads = CntW'(NumPixels);
  localparam logic [XW-1:0]   XLast      = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]   YLast      = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       readCount_q, readCount_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  rdPending_q, rdPending_d;
  logic [1:0]            fifoCount_q, fifoCount_d;
  logic [DATA_WIDTH-1:0] fifo0_q, fifo0_d;
  logic [DATA_WIDTH-1:0] fifo1_q, fifo1_d;
  logic [XW-1:0]         xCount_q, xCount_d;
  logic [YW-1:0]         yCount_q, yCount_d;

  logic                  readEn;
  logic                  pop;
  logic                  push;
  logic                  lastPixel;
  logic [2:0]            occupancy;
  logic [ADDR_WIDTH-1:0] readAddr;

  assign pop       = (fifoCount_q != 2'd0) && m_ready_i;
  assign push      = rdPending_q;
  assign lastPixel = (xCount_q == XLast) && (yCount_q == YLast);
  assign occupancy = {1'b0, fifoCount_q} + {2'b00, rdPending_q};
  // The first read is issued in the start cycle itself so the first pixel appears two cycles later.
  assign readAddr  = (state_q == IDLE) ? base_addr_i : base_q + ADDR_WIDTH'(readCount_q);

  always_comb begin
    state_d     = state_q;
    readCount_d = readCount_q;
    base_d      = base_q;
    xCount_d    = xCount_q;
    yCount_d    = yCount_q;
    readEn      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          readEn      = 1'b1;
          state_d     = STREAM;
          base_d      = base_addr_i;
          readCount_d = CntW'(1);
          xCount_d    = '0;
          yCount_d    = '0;
        end
      end
      STREAM: begin
        if ((readCount_q != TotalReads) && (occupancy < (pop ? 3'd3 : 3'd2))) begin
          readEn      = 1'b1;
          readCount_d = readCount_q + CntW'(1);
        end
        if (pop && lastPixel) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      if (xCount_q == XLast) begin
        xCount_d = '0;
        yCount_d = (yCount_q == YLast) ? '0 : yCount_q + YW'(1);
      end else begin
        xCount_d = xCount_q + XW'(1);
      end
    end
  end

  // Head of the FIFO always sits in fifo0 so the output never needs a read pointer.
  always_comb begin
    fifo0_d     = fifo0_q;
    fifo1_d     = fifo1_q;
    fifoCount_d = fifoCount_q;
    rdPending_d = readEn;

    case ({push, pop})
      2'b10: begin
        if (fifoCount_q == 2'd0) begin
          fifo0_d = mem_rdata_i;
        end else begin
          fifo1_d = mem_rdata_i;
        end
        fifoCount_d = fifoCount_q + 2'd1;
      end
      2'b01: begin
        fifo0_d     = fifo1_q;
        fifoCount_d = fifoCount_q - 2'd1;
      end
      2'b11: begin
        if (fifoCount_q == 2'd1) begin
          fifo0_d = mem_rdata_i;
        end else begin
          fifo0_d = fifo1_q;
          fifo1_d = mem_rdata_i;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      readCount_q <= '0;
      base_q      <= '0;
      rdPending_q <= 1'b0;
      fifoCount_q <= 2'd0;
      fifo0_q     <= '0;
      fifo1_q     <= '0;
      xCount_q    <= '0;
      yCount_q    <= '0;
    end else begin
      state_q     <= state_d;
      readCount_q <= readCount_d;
      base_q      <= base_d;
      rdPending_q <= rdPending_d;
      fifoCount_q <= fifoCount_d;
      fifo0_q     <= fifo0_d;
      fifo1_q     <= fifo1_d;
      xCount_q    <= xCount_d;
      yCount_q    <= yCount_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign mem_rd_en_o = readEn && rst_ni;
  assign mem_addr_o  = mem_rd_en_o ? readAddr : '0;
  assign m_valid_o   = (fifoCount_q != 2'd0);
  assign m_data_o    = fifo0_q;
  assign m_sol_o     = m_valid_o && (xCount_q == '0);
  assign m_eol_o     = m_valid_o && (xCount_q == XLast);
  assign m_sof_o     = m_valid_o && (xCount_q == '0) && (yCount_q == '0);
  assign m_eof_o     = m_valid_o && lastPixel;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: a 4x3 instance and a 1x1 instance, each fed by a
// one-cycle-latency memory model, checked against a pixel-index reference model.
module tb_pixel_stream_source;

  logic        clk = 1'b0;
  logic        rstN;
  logic        startReq;
  logic [15:0] baseAddr;
  logic        mReady;
  int          sel;
  int          checks = 0;
  int          failures = 0;

  logic        startA, busyA, doneA, rdEnA, validA, solA, eolA, sofA, eofA;
  logic [15:0] addrA;
  logic [7:0]  rdataA, dataA;
  logic        startB, busyB, doneB, rdEnB, validB, solB, eolB, sofB, eofB;
  logic [15:0] addrB;
  logic [7:0]  rdataB, dataB;

  logic        obsBusy, obsDone, obsRdEn, obsValid;
  logic [15:0] obsAddr;
  logic [7:0]  obsData;
  logic [3:0]  obsFlags;

  always #5 clk = ~clk;

  assign startA = startReq && (sel == 0);
  assign startB = startReq && (sel == 1);

  assign obsBusy  = (sel == 0) ? busyA : busyB;
  assign obsDone  = (sel == 0) ? doneA : doneB;
  assign obsRdEn  = (sel == 0) ? rdEnA : rdEnB;
  assign obsValid = (sel == 0) ? validA : validB;
  assign obsAddr  = (sel == 0) ? addrA : addrB;
  assign obsData  = (sel == 0) ? dataA : dataB;
  assign obsFlags = (sel == 0) ? {solA, eolA, sofA, eofA} : {solB, eolB, sofB, eofB};

  pixel_stream_source #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(3), .ADDR_WIDTH(16)) dutA (
    .clk_i(clk), .rst_ni(rstN), .start_i(startA), .base_addr_i(baseAddr),
    .busy_o(busyA), .done_o(doneA), .mem_rd_en_o(rdEnA), .mem_addr_o(addrA),
    .mem_rdata_i(rdataA), .m_valid_o(validA), .m_ready_i(mReady), .m_data_o(dataA),
    .m_sol_o(solA), .m_eol_o(eolA), .m_sof_o(sofA), .m_eof_o(eofA)
  );

  pixel_stream_source #(.DATA_WIDTH(8), .IMG_WIDTH(1), .IMG_HEIGHT(1), .ADDR_WIDTH(16)) dutB (
    .clk_i(clk), .rst_ni(rstN), .start_i(startB), .base_addr_i(baseAddr),
    .busy_o(busyB), .done_o(doneB), .mem_rd_en_o(rdEnB), .mem_addr_o(addrB),
    .mem_rdata_i(rdataB), .m_valid_o(validB), .m_ready_i(mReady), .m_data_o(dataB),
    .m_sol_o(solB), .m_eol_o(eolB), .m_sof_o(sofB), .m_eof_o(eofB)
  );

  // Memory returns the low address byte one cycle after a read; garbage otherwise.
  always @(posedge clk) begin
    rdataA <= rdEnA ? addrA[7:0] : 8'($urandom);
    rdataB <= rdEnB ? addrB[7:0] : 8'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rdy);
    @(negedge clk);
    startReq = st;
    mReady   = rdy;
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, obsBusy, 0);
    checkOutput({tag, "_done"}, obsDone, 0);
    checkOutput({tag, "_rd_en"}, obsRdEn, 0);
    checkOutput({tag, "_valid"}, obsValid, 0);
    checkOutput({tag, "_flags"}, obsFlags, 0);
  endtask

  // mode: 0 = ready held high, 1 = ready pattern 1,0,0,1, 2 = random ready.
  task automatic runFrame(input int s, input logic [15:0] base, input int mode,
                          input int abortAfter, input bit noise);
    int w, h, n, k, r, eofCyc;
    bit prevStall, firstSeen, finished;
    logic rdy;
    logic [15:0] expAddr;
    logic [3:0] expFlags;
    w = (s == 0) ? 4 : 1;
    h = (s == 0) ? 3 : 1;
    n = w * h;
    k = 0; r = 0; eofCyc = -1;
    prevStall = 0; firstSeen = 0; finished = 0;
    sel = s;
    baseAddr = base;

    applyStimulus(1'b1, 1'b1);
    checkOutput("start_rd_en", obsRdEn, 1);
    checkOutput("start_addr", obsAddr, base);
    checkOutput("start_busy", obsBusy, 0);
    r = 1;

    for (int cyc = 1; cyc < 150; cyc++) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      applyStimulus(noise && ((cyc == 3) || (eofCyc >= 0 && cyc == eofCyc + 1)), rdy);

      if (eofCyc >= 0 && cyc == eofCyc + 2) begin
        checkIdleOutputs("after_done");
        finished = 1;
        break;
      end

      checkOutput("busy", obsBusy, 1);
      checkOutput("done", obsDone, (eofCyc >= 0 && cyc == eofCyc + 1));
      if (prevStall) checkOutput("valid_hold", obsValid, 1);
      if (obsValid && !firstSeen) begin
        firstSeen = 1;
        checkOutput("first_valid_cycle", cyc, 2);
      end
      if (obsRdEn) begin
        expAddr = base + 16'(r);
        checkOutput("rd_addr", obsAddr, expAddr);
        r++;
      end
      if (obsValid) begin
        if (k < n) begin
          expAddr  = base + 16'(k);
          expFlags = {((k % w) == 0), ((k % w) == w - 1), (k == 0), (k == n - 1)};
          checkOutput("pixel_data", obsData, expAddr[7:0]);
          checkOutput("pixel_flags", obsFlags, expFlags);
        end else begin
          checkOutput("extra_pixel", k, n - 1);
        end
        if (rdy) begin
          k++;
          if (k == n) eofCyc = cyc;
        end
      end
      prevStall = obsValid && !rdy;
      checkOutput("outstanding_le_2", ((r - k) <= 2), 1);

      if (abortAfter > 0 && k == abortAfter) begin
        @(negedge clk);
        rstN = 1'b0;
        startReq = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkIdleOutputs("abort_reset");
        checkOutput("abort_data", obsData, 0);
        checkOutput("abort_addr", obsAddr, 0);
        repeat (3) begin
          applyStimulus(1'b0, 1'b1);
          checkOutput("abort_no_stale", obsValid, 0);
        end
        return;
      end
    end

    checkOutput("frame_finished", finished, 1);
    checkOutput("pixel_count", k, n);
    checkOutput("read_count", r, n);
  endtask

  initial begin
    rstN = 1'b0;
    startReq = 1'b0;
    mReady = 1'b0;
    baseAddr = 16'h0000;
    sel = 0;
    repeat (2) @(negedge clk);
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset_data", obsData, 0);
    checkOutput("reset_addr", obsAddr, 0);
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] 4x3 frame, ready high");
    runFrame(0, 16'h0100, 0, 0, 0);
    $display("[TB] 4x3 frame, ready 1,0,0,1");
    runFrame(0, 16'h0100, 1, 0, 0);
    $display("[TB] 4x3 frame, address wrap");
    runFrame(0, 16'hFFFE, 0, 0, 0);
    $display("[TB] 4x3 frame, start noise in STREAM and DONE");
    runFrame(0, 16'h0100, 0, 0, 1);
    $display("[TB] reset after 5 handshakes, then restart");
    runFrame(0, 16'h0040, 0, 5, 0);
    runFrame(0, 16'h0040, 0, 0, 0);
    $display("[TB] 1x1 frame");
    runFrame(1, 16'h0123, 0, 0, 0);
    $display("[TB] randomized frames");
    for (int i = 0; i < 4; i++) begin
      runFrame(0, 16'($urandom), 2, 0, 1'($urandom_range(0, 1)));
    end
    runFrame(1, 16'($urandom), 2, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
